vector_lane_pipe: RTL and testbench
===================================

VECTOR_LANE_PIPE -- requirements
Module: vector_lane_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LANES, 8, number of lanes.
- LANE_W, 8, bits per lane.
- DEPTH, 3, pipeline stages; legal range 1..8.
- TAG_W, 3, width of the destination-register tag.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- in_valid, in, 1, operation offered.
- in_ready, out, 1, pipe accepts the operation this cycle.
- in_op, in, 3, lane opcode.
- in_a, in, LANES*LANE_W, vector operand A; lane i is bits [i*LANE_W +: LANE_W].
- in_b, in, LANES*LANE_W, vector operand B, same lane layout.
- in_tag, in, TAG_W, destination tag; carried unchanged.
- flush, in, 1, discard everything in flight.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer takes the result.
- out_data, out, LANES*LANE_W, result vector.
- out_tag, out, TAG_W, tag of the result.
- busy, out, 1, at least one stage holds a valid entry.
- done_count, out, 16, number of completed output handshakes.

Function
REQ-003 Input handshake SHALL occur when in_valid && in_ready; output handshake SHALL occur when out_valid && out_ready.
REQ-004 Opcodes SHALL act per lane, unsigned, LANE_W bits wide:
- 000 ADD, wrap-around.
- 001 SUB, wrap-around.
- 010 AND.
- 011 OR.
- 100 XOR.
- 101 ADDS, saturating add.
- 110 MINU, unsigned minimum.
- 111 BCAST: every lane takes lane 0 of B.
REQ-005 The lane result SHALL be computed in stage 0 and registered; stages 1..DEPTH-1 SHALL only delay the result and tag.
REQ-006 With no stall, out_valid SHALL rise exactly DEPTH cycles after the input handshake; throughput SHALL be one operation per cycle.
REQ-007 Stage k SHALL load when its valid bit is clear or stage k+1 loads; the last stage loads when out_valid is low or out_ready is high; in_ready SHALL equal stage 0's load condition.
REQ-008 A full pipe with out_ready low SHALL hold every stage, out_data and out_tag stable; no entry SHALL be lost or duplicated.
REQ-009 Results SHALL leave in acceptance order.
REQ-010 Flush SHALL clear all valid bits at the next edge, with priority over every load; a same-cycle input handshake SHALL be dropped, and in_ready SHALL be low while flush is high.
REQ-011 A same-cycle output handshake and flush SHALL count the output; the entry is lost from the pipe either way.
REQ-012 done_count SHALL increment by 1 per output handshake and wrap from 0xFFFF to 0x0000.
REQ-013 busy SHALL be the OR of all stage valid bits.

Reset
REQ-014 Reset SHALL clear:
- all stage valid bits, so out_valid=0 and busy=0;
- out_data=0, out_tag=0 and done_count=0.
REQ-015 Reset SHALL take precedence over flush and over both handshakes.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight entries; in_ready SHALL be low during reset and high in the first cycle after it.

Configuration
REQ-017 Macro VECTOR_LANE_PIPE_SAT_EN SHALL control opcode 101:
- defined: ADDS saturates each lane to 2^LANE_W-1;
- undefined: opcode 101 SHALL behave identically to ADD and no saturation logic is compiled.

Structure
REQ-018 A shared package vlp_pkg SHALL hold:
- the opcode enum (vlp_op_e);
- the ALL_ONES lane constant;
- the done-counter width constant (16).
REQ-019 The per-lane datapath SHALL be a sub-module vlp_lane_alu (op, a, b, b_lane0 -> y), instantiated LANES times by a generate loop; the stage registers and handshake logic SHALL stay in vector_lane_pipe.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults, LANE_W=8):
- ADD, lanes A=0xF0 and B=0x20, out_ready=1 -> after 3 cycles out_valid=1, every lane 0x10, out_tag equal to in_tag.
- ADDS, same operands -> with VECTOR_LANE_PIPE_SAT_EN every lane 0xFF; without it every lane 0x10.
- BCAST, B lane0=0x5A and other B lanes 0x00 -> all lanes 0x5A; MINU with A=0x03, B=0x07 -> 0x03.
- Back-to-back stream of 5 ops with out_ready=0 -> in_ready falls after 3 accepts; raising out_ready drains all 5 in order, done_count=5.
- 3 ops in flight, flush together with in_valid -> next cycle busy=0, out_valid=0, no output appears, done_count unchanged.
- Reset asserted while full -> next cycle out_valid=0, busy=0, done_count=0, out_data=0; after 0xFFFF handshakes one more handshake gives done_count=0x0000.

Source files
------------

// File: rtl/vlp_pkg.sv
// Shared types and constants for vector_lane_pipe: lane opcodes, lane saturation value and
// done-counter width.
package vlp_pkg;

  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpSub   = 3'b001,
    OpAnd   = 3'b010,
    OpOr    = 3'b011,
    OpXor   = 3'b100,
    OpAdds  = 3'b101,
    OpMinu  = 3'b110,
    OpBcast = 3'b111
  } vlp_op_e;

  localparam int unsigned MAX_LANE_W = 64;
  // Sliced down to the lane width at the point of use.
  localparam logic [MAX_LANE_W-1:0] ALL_ONES = '1;

  localparam int unsigned DONE_W = 16;

endpackage

// File: rtl/vlp_lane_alu.sv
// One unsigned lane of the vector datapath. Opcode 101 saturates only when
// VECTOR_LANE_PIPE_SAT_EN is defined; otherwise it is a plain wrap-around add.
module vlp_lane_alu
  import vlp_pkg::*;
#(
  parameter int unsigned LANE_W = 8
) (
  input  vlp_op_e           op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [LANE_W-1:0] b_lane0,
  output logic [LANE_W-1:0] y
);

  logic [LANE_W-1:0] sum;

`ifdef VECTOR_LANE_PIPE_SAT_EN
  logic carry;
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
`else
  assign sum = a + b;
`endif

  always_comb begin
    y = '0;
    unique case (op)
      OpAdd:   y = sum;
      OpSub:   y = a - b;
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpXor:   y = a ^ b;
`ifdef VECTOR_LANE_PIPE_SAT_EN
      OpAdds:  y = carry ? ALL_ONES[LANE_W-1:0] : sum;
`else
      OpAdds:  y = sum;
`endif
      OpMinu:  y = (a < b) ? a : b;
      OpBcast: y = b_lane0;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_lane_pipe.sv
// Elastic DEPTH-stage vector lane pipeline: result computed into stage 0, later stages only
// delay it. Optional lane saturation for opcode 101 via VECTOR_LANE_PIPE_SAT_EN.
module vector_lane_pipe
  import vlp_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned TAG_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [LANES*LANE_W-1:0]   in_a,
  input  logic [LANES*LANE_W-1:0]   in_b,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      busy,
  output logic [DONE_W-1:0]         done_count
);

  localparam int unsigned DATA_W = LANES * LANE_W;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  load;
  logic              load_acc;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [DONE_W-1:0] done_count_q, done_count_d;
  logic [DATA_W-1:0] alu_y;
  logic              in_fire, out_fire;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vlp_lane_alu #(
      .LANE_W (LANE_W)
    ) u_alu (
      .op      (vlp_op_e'(in_op)),
      .a       (in_a[i*LANE_W +: LANE_W]),
      .b       (in_b[i*LANE_W +: LANE_W]),
      .b_lane0 (in_b[LANE_W-1:0]),
      .y       (alu_y[i*LANE_W +: LANE_W])
    );
  end

  // A stage may load when it is empty or everything downstream of it advances.
  always_comb begin
    load     = '0;
    load_acc = !valid_q[DEPTH-1] || out_ready;
    load[DEPTH-1] = load_acc;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      load_acc = !valid_q[k] || load_acc;
      load[k]  = load_acc;
    end
  end

  assign in_ready  = load[0] && !flush && !reset;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = valid_q[DEPTH-1];
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    tag_d        = tag_q;
    done_count_d = done_count_q;

    if (load[0]) begin
      valid_d[0] = in_fire;
      if (in_fire) begin
        data_d[0] = alu_y;
        tag_d[0]  = in_tag;
      end
    end

    for (int k = 1; k < int'(DEPTH); k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        // Bubbles move forward without disturbing held data.
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          tag_d[k]  = tag_q[k-1];
        end
      end
    end

    if (flush) begin
      valid_d = '0;
    end

    if (out_fire) begin
      done_count_d = done_count_q + DONE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      done_count_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      done_count_q <= done_count_d;
    end
  end

  assign out_data   = data_q[DEPTH-1];
  assign out_tag    = tag_q[DEPTH-1];
  assign busy       = |valid_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_vector_lane_pipe.sv
// Self-checking bench for vector_lane_pipe: vector table, directed stall/flush/reset/wrap
// sequences and a randomized scoreboard run against a lane-level arithmetic model.
module tb_vector_lane_pipe;

  localparam int LANES  = 8;
  localparam int LANE_W = 8;
  localparam int DEPTH  = 3;
  localparam int TAG_W  = 3;
  localparam int DW     = LANES * LANE_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [15:0]      done_count;

  int checks   = 0;
  int failures = 0;

  vector_lane_pipe #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       op;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    exp;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  exp_t sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lane_model(input int op, input int a, input int b, input int b0);
    int r;
    case (op)
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
`ifdef VECTOR_LANE_PIPE_SAT_EN
        r = (a + b > 255) ? 255 : a + b;
`else
        r = (a + b) % 256;
`endif
      end
      6: r = (a < b) ? a : b;
      7: r = b0;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  function automatic logic [DW-1:0] vec_model(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      r[i*8 +: 8] = lane_model(int'(op), int'(a[i*8 +: 8]), int'(b[i*8 +: 8]), int'(b[7:0]));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Three ADD ops into an empty pipe with the consumer stalled.
  task automatic fill3();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_a     = {8{8'(i + 1)}};
      in_b     = {8{8'h01}};
      in_tag   = 3'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

`ifdef VECTOR_LANE_PIPE_SAT_EN
  localparam logic [DW-1:0] ADDS_EXP0 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] ADDS_EXP1 = 64'hFFFF_FF00_FFFF_7FFF;
`else
  localparam logic [DW-1:0] ADDS_EXP0 = 64'h1010_1010_1010_1010;
  localparam logic [DW-1:0] ADDS_EXP1 = 64'h00FF_0000_FF00_7FFF;
`endif

  initial begin
    int lat;
    bit seen;
    int issued;
    int recv;
    int outs;
    int model_done;
    logic [DW-1:0] bp_a [5];
    logic exp_ready;

    vecs[0] = '{3'd0, 64'hF0F0_F0F0_F0F0_F0F0, 64'h2020_2020_2020_2020, 3'd5,
                64'h1010_1010_1010_1010};
    vecs[1] = '{3'd5, 64'hF0F0_F0F0_F0F0_F0F0, 64'h2020_2020_2020_2020, 3'd6, ADDS_EXP0};
    vecs[2] = '{3'd7, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_005A, 3'd1,
                64'h5A5A_5A5A_5A5A_5A5A};
    vecs[3] = '{3'd6, 64'h0303_0303_0303_0303, 64'h0707_0707_0707_0707, 3'd2,
                64'h0303_0303_0303_0303};
    vecs[4] = '{3'd1, 64'h1010_1010_1010_1010, 64'h2020_2020_2020_2020, 3'd3,
                64'hF0F0_F0F0_F0F0_F0F0};
    vecs[5] = '{3'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'h3C3C_3C3C_3C3C_3C3C, 3'd4,
                64'h3030_3030_3030_3030};
    vecs[6] = '{3'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'h3C3C_3C3C_3C3C_3C3C, 3'd7,
                64'hFCFC_FCFC_FCFC_FCFC};
    vecs[7] = '{3'd4, 64'hF0F0_F0F0_F0F0_F0F0, 64'h3C3C_3C3C_3C3C_3C3C, 3'd0,
                64'hCCCC_CCCC_CCCC_CCCC};
    vecs[8] = '{3'd6, 64'h00FF_7F80_0102_FE01, 64'h0100_807F_0201_FF00, 3'd3,
                64'h0000_7F7F_0101_FE00};
    vecs[9] = '{3'd5, 64'h807F_FF00_01C0_40FE, 64'h8080_0100_FE40_3F01, 3'd6, ADDS_EXP1};

    // Reset state
    set_idle();
    reset    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_during_reset", 64'(in_ready), 64'd0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_count", 64'(done_count), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    tick();

    // Opcode table: single op, free-flowing consumer, latency must equal DEPTH
    for (int v = 0; v < NV; v++) begin
      in_valid  = 1'b1;
      in_op     = vecs[v].op;
      in_a      = vecs[v].a;
      in_b      = vecs[v].b;
      in_tag    = vecs[v].tag;
      out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", v), 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (lat <= 10 && !seen) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
        else begin
          tick();
          lat++;
        end
      end
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'(DEPTH));
      check($sformatf("vec%0d_data", v), out_data, vecs[v].exp);
      check($sformatf("vec%0d_tag", v), 64'(out_tag), 64'(vecs[v].tag));
      tick();
    end

    // Backpressure: five ops offered, consumer stalled for six cycles
    do_reset();
    issued = 0;
    recv   = 0;
    for (int c = 0; c < 40 && recv < 5; c++) begin
      out_ready = (c >= 6);
      in_valid  = (issued < 5);
      in_op     = 3'd0;
      in_a      = {8{8'(issued + 1)}};
      in_b      = {8{8'h10}};
      in_tag    = 3'(issued);
      if (issued < 5) bp_a[issued] = in_a;
      @(negedge clk);
      if (c == 5) begin
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        check("bp_accepts_before_stall", 64'(issued), 64'd3);
        check("bp_out_valid_held", 64'(out_valid), 64'd1);
        check("bp_out_tag_held", 64'(out_tag), 64'd0);
        check("bp_out_data_held", out_data, vec_model(3'd0, bp_a[0], {8{8'h10}}));
      end
      if (in_valid && in_ready) issued++;
      if (out_valid && out_ready) begin
        check($sformatf("bp_order_tag%0d", recv), 64'(out_tag), 64'(recv));
        check($sformatf("bp_data%0d", recv), out_data, vec_model(3'd0, bp_a[recv], {8{8'h10}}));
        recv++;
      end
      tick();
    end
    set_idle();
    @(negedge clk);
    check("bp_drained_count", 64'(recv), 64'd5);
    check("bp_done_count", 64'(done_count), 64'd5);
    check("bp_busy_after_drain", 64'(busy), 64'd0);
    tick();

    // Reset while full overrides flush and a pending output handshake
    fill3();
    @(negedge clk);
    check("full_out_valid", 64'(out_valid), 64'd1);
    tick();
    reset     = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_reset_full", 64'(in_ready), 64'd0);
    tick();
    set_idle();
    reset = 1'b0;
    @(negedge clk);
    check("rf_out_valid", 64'(out_valid), 64'd0);
    check("rf_busy", 64'(busy), 64'd0);
    check("rf_done_count", 64'(done_count), 64'd0);
    check("rf_out_data", out_data, 64'd0);
    check("rf_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Flush with three in flight and a simultaneous offer
    fill3();
    flush    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    outs = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (out_valid) outs++;
    end
    check("flush_no_output", 64'(outs), 64'd0);
    check("flush_done_count", 64'(done_count), 64'd0);
    tick();

    // Flush coinciding with an output handshake still counts it
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'd4;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check("fo_out_valid_reached", 64'(seen), 64'd1);
    tick();
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    tick();
    set_idle();
    @(negedge clk);
    check("fo_done_count", 64'(done_count), 64'd1);
    check("fo_busy", 64'(busy), 64'd0);
    outs = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      if (out_valid) outs++;
    end
    check("fo_dropped_input", 64'(outs), 64'd0);
    tick();

    // Randomized traffic against the scoreboard
    do_reset();
    sb.delete();
    model_done = 0;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_op     = 3'($urandom);
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      in_tag    = 3'($urandom);
      @(negedge clk);
      exp_ready = !flush && (sb.size() < DEPTH || out_ready);
      check("rnd_in_ready", 64'(in_ready), 64'(exp_ready));
      check("rnd_busy", 64'(busy), 64'(sb.size() != 0));
      if (out_valid) begin
        check("rnd_out_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          check("rnd_out_data", out_data, sb[0].data);
          check("rnd_out_tag", 64'(out_tag), 64'(sb[0].tag));
          if (out_ready) begin
            void'(sb.pop_front());
            model_done++;
          end
        end
      end
      if (in_valid && exp_ready) sb.push_back('{vec_model(in_op, in_a, in_b), in_tag});
      if (flush) sb.delete();
      tick();
    end
    set_idle();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check("drain_out_data", out_data, sb[0].data);
        check("drain_out_tag", 64'(out_tag), 64'(sb[0].tag));
        void'(sb.pop_front());
        model_done++;
      end
      tick();
    end
    @(negedge clk);
    check("rnd_all_drained", 64'(sb.size()), 64'd0);
    check("rnd_done_count", 64'(done_count), 64'(16'(model_done)));
    tick();

    // done_count wrap after 0xFFFF handshakes
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_op     = 3'd0;
    seen = 1'b0;
    for (int c = 0; c < 70000 && !seen; c++) begin
      @(negedge clk);
      if (done_count == 16'hFFFF) seen = 1'b1;
      else tick();
    end
    check("wrap_reached_ffff", 64'(done_count), 64'hFFFF);
    check("wrap_pending_handshake", 64'(out_valid), 64'd1);
    tick();
    @(negedge clk);
    check("wrap_to_zero", 64'(done_count), 64'd0);
    set_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
